// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with pedestrian shortening
// and a flashing-yellow night mode, all timed from a 1 s tick.
module traffic_light_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int T_GREEN_A = 25,
  parameter int T_GREEN_B = 25,
  parameter int T_YELLOW  = 5,
  parameter int T_ALLRED  = 2,
  parameter int T_PED_MIN = 5,
  parameter int CNT_W     = 6
) (
  input  logic             CLK1K,
  input  logic             RST,
  input  logic             ped_req_A,
  input  logic             ped_req_B,
  input  logic             night,
  output logic [2:0]       led_A,
  output logic [2:0]       led_B,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase,
  output logic             tick
);

  localparam logic [2:0] CLR_A = 3'd0;
  localparam logic [2:0] GRN_A = 3'd1;
  localparam logic [2:0] YEL_A = 3'd2;
  localparam logic [2:0] CLR_B = 3'd3;
  localparam logic [2:0] GRN_B = 3'd4;
  localparam logic [2:0] YEL_B = 3'd5;
  localparam logic [2:0] NIGHT = 3'd6;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [CNT_W-1:0] C_GA  = CNT_W'(T_GREEN_A - 1);
  localparam logic [CNT_W-1:0] C_GB  = CNT_W'(T_GREEN_B - 1);
  localparam logic [CNT_W-1:0] C_Y   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] C_AR  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] C_PED = CNT_W'(T_PED_MIN - 1);
  localparam logic [CNT_W-1:0] R_RST = CNT_W'(T_ALLRED);

  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_a_q, pend_a_d;
  logic             pend_b_q, pend_b_d;
  logic             blink_q, blink_d;
  logic [2:0]       led_a_q, led_a_d;
  logic [2:0]       led_b_q, led_b_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [2:0]       phase_q, phase_d;
  logic             trunc_a, trunc_b;
  logic             is_green;

  assign tick = (presc_q == PRE_MAX);

  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    is_green = (state_q == GRN_A) || (state_q == GRN_B);
    trunc_a  = (state_q == GRN_A) && (pend_a_q || ped_req_A) &&
               (cnt_q > C_PED);
    trunc_b  = (state_q == GRN_B) && (pend_b_q || ped_req_B) &&
               (cnt_q > C_PED);

    if (state_q == NIGHT) begin
      if (tick) begin
        if (!night) begin
          state_d = CLR_A;
          cnt_d   = C_AR;
        end else begin
          blink_d = ~blink_q;
        end
      end
    end else if (trunc_a || trunc_b) begin
      cnt_d = C_PED;
    end else if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      // a green always runs out through its yellow before night mode
      end else if (night && !is_green) begin
        state_d = NIGHT;
        cnt_d   = '0;
        blink_d = 1'b1;
      end else begin
        case (state_q)
          CLR_A: begin state_d = GRN_A; cnt_d = C_GA; end
          GRN_A: begin state_d = YEL_A; cnt_d = C_Y;  end
          YEL_A: begin state_d = CLR_B; cnt_d = C_AR; end
          CLR_B: begin state_d = GRN_B; cnt_d = C_GB; end
          GRN_B: begin state_d = YEL_B; cnt_d = C_Y;  end
          default: begin state_d = CLR_A; cnt_d = C_AR; end
        endcase
      end
    end

    pend_a_d = (state_q == GRN_A) && (state_d == GRN_A) &&
               (pend_a_q || ped_req_A);
    pend_b_d = (state_q == GRN_B) && (state_d == GRN_B) &&
               (pend_b_q || ped_req_B);

    led_a_d = L_RED;
    led_b_d = L_RED;
    case (state_d)
      GRN_A: led_a_d = L_GRN;
      YEL_A: led_a_d = L_YEL;
      GRN_B: led_b_d = L_GRN;
      YEL_B: led_b_d = L_YEL;
      NIGHT: begin
        led_a_d = blink_d ? L_YEL : L_OFF;
        led_b_d = blink_d ? L_YEL : L_OFF;
      end
      default: ;
    endcase

    remain_d = (state_d == NIGHT) ? '0 : cnt_d + CNT_W'(1);
    phase_d  = state_d;
  end

  always_ff @(posedge CLK1K) begin
    if (RST) begin
      presc_q  <= '0;
      state_q  <= CLR_A;
      cnt_q    <= C_AR;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      blink_q  <= 1'b0;
      led_a_q  <= L_RED;
      led_b_q  <= L_RED;
      remain_q <= R_RST;
      phase_q  <= CLR_A;
    end else begin
      presc_q  <= presc_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      blink_q  <= blink_d;
      led_a_q  <= led_a_d;
      led_b_q  <= led_b_d;
      remain_q <= remain_d;
      phase_q  <= phase_d;
    end
  end

  assign led_A  = led_a_q;
  assign led_B  = led_b_q;
  assign remain = remain_q;
  assign phase  = phase_q;

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: CLK1K cycles per 1 s tick.
REQ-002 SHALL have parameter T_GREEN_A, default 25: road A green duration, s.
REQ-003 SHALL have parameter T_GREEN_B, default 25: road B green duration, s.
REQ-004 SHALL have parameter T_YELLOW, default 5: yellow duration, s, both roads.
REQ-005 SHALL have parameter T_ALLRED, default 2: all-red clearance before each green, s.
REQ-006 SHALL have parameter T_PED_MIN, default 5: minimum green remaining after a pedestrian request, s.
REQ-007 SHALL have parameter CNT_W, default 6: width of phase counter and remain outputs.
REQ-008 SHALL have port CLK1K, input, 1: sole clock, rising edge.
REQ-009 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-010 SHALL have port ped_req_A, input, 1: level pedestrian request to stop road A.
REQ-011 SHALL have port ped_req_B, input, 1: level pedestrian request to stop road B.
REQ-012 SHALL have port night, input, 1: night-mode request.
REQ-013 SHALL have port led_A, output, 3: road A lamps {red,yellow,green}.
REQ-014 SHALL have port led_B, output, 3: road B lamps {red,yellow,green}.
REQ-015 SHALL have port remain, output, CNT_W: seconds left in current phase.
REQ-016 SHALL have port phase, output, 3: current state code.
REQ-017 SHALL have port tick, output, 1: one-cycle 1 s strobe.

Function
REQ-018 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for exactly the cycle where prescaler = TICK_DIV-1.
REQ-019 States/codes SHALL be CLR_A=0, GRN_A=1, YEL_A=2, CLR_B=3, GRN_B=4, YEL_B=5, NIGHT=6; cycle CLR_A→GRN_A→YEL_A→CLR_B→GRN_B→YEL_B→CLR_A.
REQ-020 On entering a phase, counter SHALL load duration-1; on each tick, counter>0 decrements, counter=0 ends the phase and the next state loads in the same cycle.
REQ-021 remain SHALL equal counter+1 in all non-NIGHT states, and 0 in NIGHT.
REQ-022 Lamps SHALL be: CLR_x both 100; GRN_A A=001,B=100; YEL_A A=010,B=100; GRN_B A=100,B=001; YEL_B A=100,B=010.
REQ-023 ped_req_A high in GRN_A SHALL set latch pend_A; pend_A set and counter > T_PED_MIN-1 SHALL force counter to T_PED_MIN-1 next cycle, applied once; same for B in GRN_B.
REQ-024 pend_x SHALL clear on leaving GRN_x; requests outside GRN_x SHALL be ignored.
REQ-025 Request and tick in the same cycle: truncation SHALL take priority over decrement.
REQ-026 night SHALL be sampled only at phase end (counter=0 and tick); if high, next state SHALL be NIGHT instead of the normal successor.
REQ-027 In NIGHT, both lamps SHALL toggle between 010 and 000 on each tick, starting at 010 on entry.
REQ-028 In NIGHT, night low at a tick SHALL move to CLR_A with counter=T_ALLRED-1.
REQ-029 All outputs except tick SHALL be registered; durations SHALL be ≥1 and fit CNT_W bits; T_PED_MIN ≤ both greens.

Reset
REQ-030 RST high at a rising edge SHALL set: prescaler=0, state=CLR_A, counter=T_ALLRED-1, pend_A=pend_B=0, led_A=led_B=100, remain=T_ALLRED, phase=0, tick=0.
REQ-031 RST mid-phase, including NIGHT, SHALL abort immediately to the REQ-030 values; RST SHALL take priority over all inputs.

Verification (TICK_DIV=4, T_GREEN_A=6, T_GREEN_B=4, T_YELLOW=2, T_ALLRED=1, T_PED_MIN=2)
REQ-032 Release reset, inputs low → phases 0,1,2,3,4,5,0 lasting 1,6,2,1,4,2,1 ticks; tick every 4 cycles; remain 6..1 in GRN_A.
REQ-033 Pulse ped_req_A one cycle at GRN_A remain=5 → remain becomes 2 next cycle, then 1, then YEL_A; second pulse at remain=2 → no change.
REQ-034 ped_req_A during GRN_B → GRN_A later runs a full 6 ticks.
REQ-035 Raise night in GRN_B → NIGHT entered only after YEL_B ends; lamps 010/000 alternate per tick; drop night → CLR_A with remain=1.
REQ-036 Assert RST for one cycle in YEL_A and again in NIGHT → next cycle led_A=led_B=100, phase=0, remain=1, prescaler restarts at 0.
